fpu_norm_sequencer: RTL and testbench
=====================================

// Module: fpu_norm_sequencer
// PURPOSE
//  Multi-cycle normaliser for the FPU add/sub path, placed between the mantissa ALU and rounding.
//  - Accepts one {exp, carry, 28-bit mantissa} result per valid/ready handshake.
//  - Carry case: right-shifts by one. Otherwise left-normalises up to STEP bits per cycle,
//    sharing one leading-zero counter and one exponent decrementer.
//  - Flags overflow, underflow (denormal) and zero.
// PARAMETERS
//  EXP_W   8   exponent width
//  MANT_W  28  mantissa width (hidden bit + fraction + guard/round/sticky)
//  STEP    4   max left shift per cycle; power of 2, 1..MANT_W
// PORTS
//  i_clk       in   1       clock, rising edge
//  i_rst_n     in   1       asynchronous active-low reset
//  i_valid     in   1       input operand valid
//  o_ready     out  1       block can accept (high only in IDLE)
//  i_exp       in   EXP_W   pre-normalisation exponent
//  i_c_alu     in   1       mantissa ALU carry-out
//  i_mant      in   MANT_W  pre-normalisation mantissa
//  o_valid     out  1       result valid (high only in DONE)
//  i_ready     in   1       downstream accepts result
//  o_exp       out  EXP_W   normalised exponent
//  o_mant      out  MANT_W  normalised mantissa
//  o_overflow  out  1       exponent saturated to all-ones
//  o_underflow out  1       exp reached 0 with mant[MSB]=0 (denormal)
//  o_zero      out  1       input mantissa was zero (non-carry path)
//  o_cycles    out  5       shifting cycles used, saturating at 31
// BEHAVIOUR
//  Reset and outputs
//  - Reset clears all outputs and internal registers to 0; state goes to IDLE.
//  - Reset is honoured in any state; an in-flight operation is discarded.
//  - All outputs are registered.
//  State machine: IDLE -> EVAL -> {SHIFT | DONE}; SHIFT -> SHIFT | DONE; DONE -> IDLE.
//  - IDLE: o_ready=1. On i_valid&&o_ready, capture exp/c_alu/mant, clear o_cycles and flags,
//    go to EVAL. Inputs are ignored outside IDLE.
//  - EVAL, checks in priority order:
//    - c_alu=1: mant={1'b1, mant[MSB:2], mant[1]|mant[0]} (sticky kept); exp=exp+1;
//      if exp+1 = all-ones, set overflow. Go to DONE.
//    - mant=0: set zero, exp=0. Go to DONE.
//    - mant[MSB]=1: go to DONE.
//    - otherwise: go to SHIFT.
//  - SHIFT: s = min(lzc(mant), STEP, exp).
//    - s>0: mant<<=s, exp-=s, o_cycles++ (saturating).
//    - s=0: go to DONE. Set underflow if exp=0 and mant[MSB]=0.
//  - DONE entry: if exp = all-ones, set overflow. Overflow in any path forces exp=all-ones, mant=0.
//  - DONE: o_valid=1; outputs held stable while i_ready=0.
//    On i_ready, go to IDLE; o_ready rises the next cycle.
//  Latency (edges after the accepting edge until o_valid)
//  - 1 for carry, zero and already-normalised inputs.
//  - 2 + shifting cycles otherwise.
//  Width and output rules
//  - Exponent arithmetic is done in EXP_W+1 bits, then saturated.
//  - Throughput is one operation per (latency+2) cycles; no overlap.
//  - o_exp/o_mant/flags update only on entry to DONE. In other states they hold their last value.
// STRUCTURE
//  - fpu_pkg: EXP_W/MANT_W constants, norm_state_t enum {IDLE,EVAL,SHIFT,DONE}.
//  - Sub-module fpu_lzc: combinational MANT_W leading-zero count (returns MANT_W for 0).
//  - The min/shift/decrement datapath and the FSM live in this module.
// TESTING (STEP=4)
//  1. c_alu=1, exp=0x80, mant=0x0000003 -> o_exp=0x81, o_mant=0x8000001, flags 0,
//     o_valid 1 edge after accept.
//  2. c_alu=0, exp=0x80, mant=0x0100000 (lzc=7) -> shifts 4 then 3;
//     o_exp=0x79, o_mant=0x8000000, o_cycles=2, o_valid 4 edges after accept.
//  3. c_alu=1, exp=0xFE, any mant -> o_overflow=1, o_exp=0xFF, o_mant=0.
//     Also: c_alu=0, exp=0xFF, mant=0x8000000 -> o_overflow=1.
//  4. c_alu=0, mant=0, exp=0x55 -> o_zero=1, o_exp=0x00, o_mant=0, latency 1.
//  5. c_alu=0, exp=0x03, mant=0x0000100 -> single shift of 3;
//     o_exp=0x00, o_mant=0x0000800, o_underflow=1, o_cycles=1.
//  6. Handshake/reset:
//     - hold i_ready=0 for 5 cycles in DONE -> outputs stable, o_ready=0,
//       a second i_valid is not captured;
//     - assert i_rst_n=0 mid-SHIFT -> all outputs 0 immediately, IDLE after release.

Source files
------------

// File: rtl/fpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_pkg                                                            |
// | Shared widths and normaliser state encoding for the FPU add path.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fpu_pkg;

    localparam int FPU_EXP_W  = 8;
    localparam int FPU_MANT_W = 28;
    localparam int FPU_STEP   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } norm_state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_lzc                                                            |
// | Combinational leading-zero count; an all-zero input returns WIDTH. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fpu_lzc
    import fpu_pkg::*;
#(
    parameter int WIDTH = FPU_MANT_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CNT_W-1:0] o_count
);

    // Scanning upward lets the highest set bit write last and win.
    always_comb begin
        o_count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_norm_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_norm_sequencer                                                 |
// | Multi-cycle post-ALU normaliser: carry right-shift or iterative    |
// | left-normalisation with overflow/underflow/zero flags.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fpu_norm_sequencer
    import fpu_pkg::*;
#(
    parameter int EXP_W  = FPU_EXP_W,
    parameter int MANT_W = FPU_MANT_W,
    parameter int STEP   = FPU_STEP
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic              i_c_alu,
    input  logic [MANT_W-1:0] i_mant,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [EXP_W-1:0]  o_exp,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_zero,
    output logic [4:0]        o_cycles
);

    localparam int LZ_W = $clog2(MANT_W + 1);
    localparam int SW   = (EXP_W > LZ_W) ? EXP_W : LZ_W;

    localparam logic [SW-1:0]  c_STEP    = SW'(STEP);
    localparam logic [EXP_W:0] c_EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    norm_state_t       r_state;
    logic [EXP_W-1:0]  r_exp;
    logic              r_c_alu;
    logic [MANT_W-1:0] r_mant;

    logic [LZ_W-1:0]   w_lzc;
    logic [SW-1:0]     w_shamt;
    logic [EXP_W:0]    w_fin_exp;
    logic [MANT_W-1:0] w_fin_mant;
    logic              w_fin_zero;
    logic              w_fin_uf;
    logic              w_fin_ovf;
    logic              w_to_done;

    fpu_lzc #(
        .WIDTH (MANT_W),
        .CNT_W (LZ_W)
    ) u_lzc (
        .i_data  (r_mant),
        .o_count (w_lzc)
    );

    // Shift amount is bounded by the step size and by the remaining exponent.
    always_comb begin
        w_shamt = SW'(w_lzc);
        if (c_STEP < w_shamt) begin
            w_shamt = c_STEP;
        end
        if (SW'(r_exp) < w_shamt) begin
            w_shamt = SW'(r_exp);
        end
    end

    // Result that would be presented if DONE is entered on this edge.
    always_comb begin
        w_fin_exp  = {1'b0, r_exp};
        w_fin_mant = r_mant;
        w_fin_zero = 1'b0;
        w_fin_uf   = 1'b0;
        w_to_done  = 1'b0;
        if (r_state == EVAL) begin
            if (r_c_alu) begin
                w_fin_exp  = {1'b0, r_exp} + {{EXP_W{1'b0}}, 1'b1};
                w_fin_mant = {1'b1, r_mant[MANT_W-1:2], r_mant[1] | r_mant[0]};
                w_to_done  = 1'b1;
            end else if (r_mant == '0) begin
                w_fin_exp  = '0;
                w_fin_zero = 1'b1;
                w_to_done  = 1'b1;
            end else if (r_mant[MANT_W-1]) begin
                w_to_done  = 1'b1;
            end
        end else if ((r_state == SHIFT) && (w_shamt == '0)) begin
            w_fin_uf  = (r_exp == '0) && !r_mant[MANT_W-1];
            w_to_done = 1'b1;
        end
    end

    assign w_fin_ovf = (w_fin_exp >= c_EXP_MAX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_exp       <= '0;
            r_c_alu     <= 1'b0;
            r_mant      <= '0;
            o_ready     <= 1'b0;
            o_valid     <= 1'b0;
            o_exp       <= '0;
            o_mant      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_zero      <= 1'b0;
            o_cycles    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        r_exp       <= i_exp;
                        r_c_alu     <= i_c_alu;
                        r_mant      <= i_mant;
                        o_overflow  <= 1'b0;
                        o_underflow <= 1'b0;
                        o_zero      <= 1'b0;
                        o_cycles    <= '0;
                        o_ready     <= 1'b0;
                        r_state     <= EVAL;
                    end else begin
                        o_ready <= 1'b1;
                    end
                end
                EVAL: begin
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_shamt != '0) begin
                        r_mant <= r_mant << w_shamt;
                        r_exp  <= r_exp - EXP_W'(w_shamt);
                        if (o_cycles != 5'd31) begin
                            o_cycles <= o_cycles + 5'd1;
                        end
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            // DONE entry overrides the EVAL/SHIFT next-state chosen above.
            if (w_to_done) begin
                o_exp       <= w_fin_ovf ? {EXP_W{1'b1}} : w_fin_exp[EXP_W-1:0];
                o_mant      <= w_fin_ovf ? '0 : w_fin_mant;
                o_overflow  <= w_fin_ovf;
                o_underflow <= w_fin_uf;
                o_zero      <= w_fin_zero;
                o_valid     <= 1'b1;
                r_state     <= DONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_norm_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fpu_norm_sequencer                                              |
// | Table-driven scoreboard bench for the FPU normaliser (STEP=4).     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_fpu_norm_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [7:0]  i_exp = '0;
    logic        i_c_alu = 1'b0;
    logic [27:0] i_mant = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [7:0]  o_exp;
    logic [27:0] o_mant;
    logic        o_overflow;
    logic        o_underflow;
    logic        o_zero;
    logic [4:0]  o_cycles;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0]  in_exp;
        logic        in_c;
        logic [27:0] in_mant;
        logic [7:0]  ex_exp;
        logic [27:0] ex_mant;
        logic        ex_ovf;
        logic        ex_uf;
        logic        ex_zero;
        int          ex_cyc;
        int          ex_lat;
    } vec_t;

    localparam int NV = 14;
    vec_t tbl [NV];
    vec_t sb [$];

    fpu_norm_sequencer #(
        .EXP_W  (8),
        .MANT_W (28),
        .STEP   (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_exp       (i_exp),
        .i_c_alu     (i_c_alu),
        .i_mant      (i_mant),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_exp       (o_exp),
        .o_mant      (o_mant),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
        .o_zero      (o_zero),
        .o_cycles    (o_cycles)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(o_ready), 32'd0);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_exp"},   32'(o_exp),   32'd0);
        check({tag, "_mant"},  32'(o_mant),  32'd0);
        check({tag, "_flags"}, 32'({o_overflow, o_underflow, o_zero}), 32'd0);
        check({tag, "_cyc"},   32'(o_cycles), 32'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!o_ready && n < 40) begin
            @(negedge i_clk);
            n++;
        end
    endtask

    // Drive one operation, then pop its expected result when o_valid shows up.
    task automatic run_op(input int idx, input vec_t v);
        int   n;
        vec_t e;
        string t;
        t = $sformatf("v%0d", idx);
        wait_ready();
        check({t, "_ready_wait"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_exp   = v.in_exp;
        i_c_alu = v.in_c;
        i_mant  = v.in_mant;
        sb.push_back(v);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_exp   = 8'($urandom);
        i_c_alu = 1'($urandom);
        i_mant  = 28'($urandom);
        n = 0;
        while (!o_valid && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        check({t, "_valid_seen"}, 32'(o_valid), 32'd1);
        e = sb.pop_front();
        check({t, "_exp"},   32'(o_exp),  32'(e.ex_exp));
        check({t, "_mant"},  32'(o_mant), 32'(e.ex_mant));
        check({t, "_flags"}, 32'({o_overflow, o_underflow, o_zero}),
              32'({e.ex_ovf, e.ex_uf, e.ex_zero}));
        check({t, "_cycles"},  32'(o_cycles), 32'(e.ex_cyc));
        check({t, "_latency"}, 32'(n), 32'(e.ex_lat));
        @(negedge i_clk);
        check({t, "_valid_drop"}, 32'(o_valid), 32'd0);
        check({t, "_ready_back"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        int n;
        //            in_exp c  in_mant       ex_exp ex_mant      ovf   uf    zero cyc lat
        tbl[0]  = '{8'h80, 1'b1, 28'h0000003, 8'h81, 28'h8000001, 1'b0, 1'b0, 1'b0, 0, 1};
        tbl[1]  = '{8'h80, 1'b0, 28'h0100000, 8'h79, 28'h8000000, 1'b0, 1'b0, 1'b0, 2, 4};
        tbl[2]  = '{8'hFE, 1'b1, 28'h5555555, 8'hFF, 28'h0000000, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[3]  = '{8'hFF, 1'b0, 28'h8000000, 8'hFF, 28'h0000000, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[4]  = '{8'h55, 1'b0, 28'h0000000, 8'h00, 28'h0000000, 1'b0, 1'b0, 1'b1, 0, 1};
        tbl[5]  = '{8'h03, 1'b0, 28'h0000100, 8'h00, 28'h0000800, 1'b0, 1'b1, 1'b0, 1, 3};
        tbl[6]  = '{8'h40, 1'b0, 28'hABCDEF1, 8'h40, 28'hABCDEF1, 1'b0, 1'b0, 1'b0, 0, 1};
        tbl[7]  = '{8'hFF, 1'b1, 28'h1234567, 8'hFF, 28'h0000000, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[8]  = '{8'h00, 1'b0, 28'h0001000, 8'h00, 28'h0001000, 1'b0, 1'b1, 1'b0, 0, 2};
        tbl[9]  = '{8'h10, 1'b1, 28'h0000004, 8'h11, 28'h8000002, 1'b0, 1'b0, 1'b0, 0, 1};
        tbl[10] = '{8'h80, 1'b0, 28'h0000001, 8'h65, 28'h8000000, 1'b0, 1'b0, 1'b0, 7, 9};
        tbl[11] = '{8'h05, 1'b0, 28'h0000001, 8'h00, 28'h0000020, 1'b0, 1'b1, 1'b0, 2, 4};
        tbl[12] = '{8'h07, 1'b0, 28'h0100000, 8'h00, 28'h8000000, 1'b0, 1'b0, 1'b0, 2, 4};
        tbl[13] = '{8'h80, 1'b0, 28'h0800000, 8'h7C, 28'h8000000, 1'b0, 1'b0, 1'b0, 1, 3};

        // Power-on reset
        #2 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check_all_zero("por");
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("por_ready_rise", 32'(o_ready), 32'd1);

        for (int i = 0; i < NV; i++) begin
            run_op(i, tbl[i]);
        end

        // Back-pressure: result held while i_ready=0, a new request is ignored
        i_ready = 1'b0;
        wait_ready();
        i_valid = 1'b1;
        i_exp   = tbl[1].in_exp;
        i_c_alu = tbl[1].in_c;
        i_mant  = tbl[1].in_mant;
        @(negedge i_clk);
        i_valid = 1'b0;
        n = 0;
        while (!o_valid && n < 60) begin
            @(negedge i_clk);
            n++;
        end
        check("hold_latency", 32'(n), 32'd4);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d_valid", k), 32'(o_valid), 32'd1);
            check($sformatf("hold%0d_ready", k), 32'(o_ready), 32'd0);
            check($sformatf("hold%0d_exp", k),   32'(o_exp),  32'h79);
            check($sformatf("hold%0d_mant", k),  32'(o_mant), 32'h8000000);
            check($sformatf("hold%0d_cyc", k),   32'(o_cycles), 32'd2);
            if (k == 1) begin
                i_valid = 1'b1;
                i_c_alu = 1'b1;
                i_exp   = 8'h10;
                i_mant  = 28'h0000003;
            end
            if (k == 3) begin
                i_valid = 1'b0;
            end
            @(negedge i_clk);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        check("hold_release_valid", 32'(o_valid), 32'd0);
        check("hold_release_ready", 32'(o_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check($sformatf("nocap%0d_valid", k), 32'(o_valid), 32'd0);
            check($sformatf("nocap%0d_exp", k),   32'(o_exp), 32'h79);
        end

        // Reset in the middle of a long shift sequence
        wait_ready();
        i_valid = 1'b1;
        i_exp   = tbl[10].in_exp;
        i_c_alu = tbl[10].in_c;
        i_mant  = tbl[10].in_mant;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        check("mid_shift_cycles", 32'(o_cycles), 32'd2);
        check("mid_shift_valid", 32'(o_valid), 32'd0);
        #2 i_rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        n = 0;
        while (!o_ready && n < 3) begin
            @(negedge i_clk);
            n++;
        end
        check("post_rst_ready", 32'(o_ready), 32'd1);
        check("post_rst_valid", 32'(o_valid), 32'd0);
        run_op(100, tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
